test_result_collector: RTL and testbench

- Controller that sequences the shared partial-sum comparator during self-test.
- Consumes one systolic row of partial sums per valid cycle, for N patterns, and drives the golden answer to the comparator.
- Accumulates the comparator's per-column mismatch bits into a per-PE fault map and derives the faulty-column mask.
- Decides whether the array is recoverable with the available spare columns. Sits between the test pattern generator/array output and the self-recovery (column remap) logic.

---
 rtl/test_result_collector.sv | 180 ++++++++++++++++++
 tb/tb_test_result_collector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_collector.sv
// test_result_collector
// Self-test result collector. It takes one systolic row of partial sums per
// valid cycle and drives the golden answer to the shared comparator. The
// per-column mismatch bits are OR-accumulated into a per-PE fault map. At the
// end of a session it reports how many columns are faulty and whether the
// spare columns can cover them.

module test_result_collector #(
   parameter int unsigned SYSTOLIC_SIZE     = 8,
   parameter int unsigned WEIGHT_WIDTH      = 8,
   parameter int unsigned ACTIVATION_WIDTH  = 8,
   parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
   parameter int unsigned MAX_PATTERNS      = 16,
   parameter int unsigned SPARE_COLS        = 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   input  logic                                   abort,
   input  logic [$clog2(MAX_PATTERNS+1)-1:0]      num_patterns,
   input  logic                                   row_valid,
   input  logic [PARTIAL_SUM_WIDTH-1:0]           golden_in,
   output logic [PARTIAL_SUM_WIDTH-1:0]           cmp_answer,
   input  logic [SYSTOLIC_SIZE-1:0]               cmp_result,
   output logic                                   busy,
   output logic                                   done,
   output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] fault_map,
   output logic [SYSTOLIC_SIZE-1:0]               faulty_cols,
   output logic [$clog2(SYSTOLIC_SIZE+1)-1:0]     fault_col_cnt,
   output logic                                   recoverable
);

   localparam int unsigned CNT_W    = $clog2(MAX_PATTERNS + 1);
   localparam int unsigned ROW_W    = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
   localparam int unsigned COLCNT_W = $clog2(SYSTOLIC_SIZE + 1);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SYSTOLIC_SIZE - 1);
   localparam logic [CNT_W-1:0] PAT_MAX  = CNT_W'(MAX_PATTERNS);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_REPORT  = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [ROW_W-1:0]    row_idx;
   logic [CNT_W-1:0]    pat_cnt;
   logic [CNT_W-1:0]    eff_n;
   logic [CNT_W-1:0]    eff_in;
   logic                accept_start;
   logic                capture;
   logic                last_row;
   logic [COLCNT_W-1:0] popcnt;

   assign accept_start = (state == ST_IDLE) && start;
   assign capture      = (state == ST_COLLECT) && row_valid;
   assign last_row     = (row_idx == ROW_LAST) && (pat_cnt == eff_n - CNT_W'(1));

   // Clamp the requested pattern count to the supported maximum
   always_comb begin
      eff_in = num_patterns;
      if (num_patterns > PAT_MAX) begin
         eff_in = PAT_MAX;
      end
   end

   // Golden value reaches the comparator only on valid rows while collecting
   always_comb begin
      cmp_answer = '0;
      if (capture) begin
         cmp_answer = golden_in;
      end
   end

   // Number of faulty columns, consumed in REPORT
   always_comb begin
      popcnt = '0;
      for (int unsigned i = 0; i < SYSTOLIC_SIZE; i++) begin
         popcnt = popcnt + COLCNT_W'(faulty_cols[i]);
      end
   end

   // Next-state decode; abort outranks a same-cycle final-row capture
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (eff_in != '0) ? ST_COLLECT : ST_REPORT;
            end
         end
         ST_COLLECT: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (row_valid && last_row) begin
               state_nxt = ST_REPORT;
            end
         end
         ST_REPORT: begin
            state_nxt = abort ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered status flags, decoded from the upcoming state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt != ST_IDLE);
         done <= (state_nxt == ST_DONE);
      end
   end

   // Row and pattern counters; eff_n is latched at session start
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_idx <= '0;
         pat_cnt <= '0;
         eff_n   <= '0;
      end else if (accept_start) begin
         row_idx <= '0;
         pat_cnt <= '0;
         eff_n   <= eff_in;
      end else if (capture) begin
         if (row_idx == ROW_LAST) begin
            row_idx <= '0;
            pat_cnt <= pat_cnt + CNT_W'(1);
         end else begin
            row_idx <= row_idx + ROW_W'(1);
         end
      end
   end

   // Sticky fault accumulation; a captured row is ORed in even when aborting
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_map   <= '0;
         faulty_cols <= '0;
      end else if (accept_start) begin
         fault_map   <= '0;
         faulty_cols <= '0;
      end else if (capture) begin
         fault_map[row_idx*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] <=
            fault_map[row_idx*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] | cmp_result;
         faulty_cols <= faulty_cols | cmp_result;
      end
   end

   // Column count and recoverability, updated only by an unaborted REPORT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_col_cnt <= '0;
         recoverable   <= 1'b1;
      end else if (accept_start) begin
         fault_col_cnt <= '0;
      end else if ((state == ST_REPORT) && !abort) begin
         fault_col_cnt <= popcnt;
         recoverable   <= (32'(popcnt) <= SPARE_COLS);
      end
   end

endmodule

// File: tb/tb_test_result_collector.sv
// tb_test_result_collector
// Directed and randomized sessions against a table-driven fault model. The
// comparator is modelled as an array whose column outputs equal golden_in
// except where the injected mask flips bit 0.

module tb_test_result_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [4:0]  num_patterns;
   logic        row_valid;
   logic [18:0] golden_in;
   logic [18:0] cmp_answer;
   logic [7:0]  cmp_result;
   logic        busy;
   logic        done;
   logic [63:0] fault_map;
   logic [7:0]  faulty_cols;
   logic [3:0]  fault_col_cnt;
   logic        recoverable;

   logic [7:0]  inj;
   logic [7:0]  inj_tab [0:15][0:7];
   logic [63:0] exp_map;
   int          errors = 0;
   int          checks = 0;

   test_result_collector #(
      .SYSTOLIC_SIZE(8),
      .WEIGHT_WIDTH(8),
      .ACTIVATION_WIDTH(8),
      .MAX_PATTERNS(16),
      .SPARE_COLS(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .num_patterns(num_patterns),
      .row_valid(row_valid),
      .golden_in(golden_in),
      .cmp_answer(cmp_answer),
      .cmp_result(cmp_result),
      .busy(busy),
      .done(done),
      .fault_map(fault_map),
      .faulty_cols(faulty_cols),
      .fault_col_cnt(fault_col_cnt),
      .recoverable(recoverable)
   );

   always #5 clk = ~clk;

   // Array column c produces golden_in with bit 0 flipped where inj[c] is set
   always_comb begin
      cmp_result = '0;
      for (int c = 0; c < 8; c++) begin
         cmp_result[c] = ((golden_in ^ 19'(inj[c])) != cmp_answer);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_tab();
      for (int p = 0; p < 16; p++)
         for (int r = 0; r < 8; r++)
            inj_tab[p][r] = 8'h00;
   endtask

   function automatic logic [7:0] cols_of(input logic [63:0] m);
      logic [7:0] c = 8'h00;
      for (int r = 0; r < 8; r++) c |= m[r*8 +: 8];
      return c;
   endfunction

   task automatic do_start(input int n);
      start        = 1'b1;
      abort        = 1'b0;
      num_patterns = 5'(n);
      tick();
      start   = 1'b0;
      exp_map = '0;
   endtask

   task automatic stall_cycle();
      row_valid = 1'b0;
      golden_in = 19'($urandom);
      inj       = 8'h00;
      #1;
      check("stall_answer", 64'(cmp_answer), 64'h0);
      tick();
   endtask

   task automatic drive_row(input int p, input int r, input logic [18:0] gold);
      row_valid = 1'b1;
      golden_in = gold;
      inj       = inj_tab[p][r];
      #1;
      check("pass_answer", 64'(cmp_answer), 64'(gold));
      check("collect_done", 64'(done), 64'h0);
      exp_map[r*8 +: 8] = exp_map[r*8 +: 8] | inj_tab[p][r];
      tick();
      start = 1'b0;
   endtask

   // Full session; final row timing, results and hold behaviour are checked
   task automatic run_session(input int n, input int stall, input logic [18:0] fixed_gold,
                              input int glitch_at);
      int         eff;
      int         rows;
      logic [7:0] ec;
      eff  = (n > 16) ? 16 : n;
      rows = 0;
      do_start(n);
      for (int p = 0; p < eff; p++) begin
         for (int r = 0; r < 8; r++) begin
            if (stall != 0) stall_cycle();
            if (rows == glitch_at) begin
               start        = 1'b1;
               num_patterns = 5'd0;
            end
            drive_row(p, r, (fixed_gold != 0) ? fixed_gold : 19'($urandom));
            rows++;
         end
      end
      // first cycle after the final row (or after the start edge when eff=0)
      row_valid = 1'b1;
      golden_in = 19'($urandom);
      inj       = 8'hFF;
      #1;
      check("report_answer", 64'(cmp_answer), 64'h0);
      check("report_done", 64'(done), 64'h0);
      check("report_busy", 64'(busy), 64'h1);
      tick();
      ec = cols_of(exp_map);
      check("done_pulse", 64'(done), 64'h1);
      check("done_busy", 64'(busy), 64'h1);
      check("fault_map", fault_map, exp_map);
      check("faulty_cols", 64'(faulty_cols), 64'(ec));
      check("fault_col_cnt", 64'(fault_col_cnt), 64'($countones(ec)));
      check("recoverable", 64'(recoverable), 64'($countones(ec) <= 1));
      tick();
      row_valid = 1'b0;
      inj       = 8'h00;
      check("after_done", 64'(done), 64'h0);
      check("after_busy", 64'(busy), 64'h0);
      check("hold_map", fault_map, exp_map);
      tick();
      check("idle_done", 64'(done), 64'h0);
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      num_patterns = 5'd0;
      row_valid    = 1'b0;
      golden_in    = '0;
      inj          = 8'h00;
      exp_map      = '0;
      clear_tab();
      tick();
      tick();
      check("rst_map", fault_map, 64'h0);
      check("rst_cols", 64'(faulty_cols), 64'h0);
      check("rst_cnt", 64'(fault_col_cnt), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_rec", 64'(recoverable), 64'h1);
      rst_n = 1'b1;
      tick();

      // fault-free, two patterns
      clear_tab();
      run_session(2, 0, 19'h0, -1);

      // single PE: pattern 1 row 3 column 5 -> bit 29
      clear_tab();
      inj_tab[1][3] = 8'h20;
      run_session(2, 0, 19'h0, -1);
      check("single_bit29", fault_map, 64'h1 << 29);

      // two faulty columns exceed one spare
      clear_tab();
      inj_tab[0][1] = 8'h01;
      inj_tab[1][6] = 8'h80;
      run_session(2, 0, 19'h0, -1);
      check("unrec_cols", 64'(faulty_cols), 64'h81);

      // stalls on every other cycle with a fixed golden value
      clear_tab();
      inj_tab[0][4] = 8'h0C;
      run_session(1, 1, 19'h1234A, -1);

      // zero patterns
      clear_tab();
      run_session(0, 0, 19'h0, -1);

      // request above the maximum is clamped to 16 patterns (128 rows)
      clear_tab();
      for (int p = 0; p < 16; p++)
         for (int r = 0; r < 8; r++)
            inj_tab[p][r] = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_session(20, 0, 19'h0, -1);

      // start during COLLECT is ignored
      clear_tab();
      inj_tab[0][2] = 8'h10;
      inj_tab[1][7] = 8'h10;
      run_session(2, 0, 19'h0, 5);

      // randomized sessions
      for (int k = 0; k < 4; k++) begin
         clear_tab();
         for (int p = 0; p < 4; p++)
            for (int r = 0; r < 8; r++)
               inj_tab[p][r] = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         run_session($urandom_range(1, 4), $urandom_range(0, 1), 19'h0, -1);
      end

      // abort after five rows keeps the partial map and produces no done
      clear_tab();
      for (int r = 0; r < 5; r++) inj_tab[0][r] = 8'(1 << r);
      do_start(2);
      for (int r = 0; r < 5; r++) drive_row(0, r, 19'($urandom));
      abort     = 1'b1;
      row_valid = 1'b0;
      tick();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_done", 64'(done), 64'h0);
      check("abort_map", fault_map, exp_map);
      check("abort_cnt", 64'(fault_col_cnt), 64'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_done", 64'(done), 64'h0);
      end
      clear_tab();
      run_session(1, 0, 19'h0, -1);
      check("restart_clean", fault_map, 64'h0);

      // abort coinciding with the final row: row captured, no report
      clear_tab();
      inj_tab[0][2] = 8'h04;
      inj_tab[0][7] = 8'h40;
      do_start(1);
      for (int r = 0; r < 7; r++) drive_row(0, r, 19'($urandom));
      abort = 1'b1;
      drive_row(0, 7, 19'($urandom));
      abort     = 1'b0;
      row_valid = 1'b0;
      inj       = 8'h00;
      check("abort_last_busy", 64'(busy), 64'h0);
      check("abort_last_map", fault_map, exp_map);
      check("abort_last_cols", 64'(faulty_cols), 64'h44);
      check("abort_last_cnt", 64'(fault_col_cnt), 64'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_last_no_done", 64'(done), 64'h0);
      end

      // unrecoverable result, then reset mid-COLLECT
      clear_tab();
      inj_tab[0][0] = 8'h03;
      run_session(1, 0, 19'h0, -1);
      clear_tab();
      inj_tab[0][0] = 8'hF0;
      inj_tab[0][1] = 8'h0F;
      do_start(1);
      for (int r = 0; r < 3; r++) drive_row(0, r, 19'($urandom));
      rst_n     = 1'b0;
      row_valid = 1'b0;
      inj       = 8'h00;
      tick();
      check("mrst_map", fault_map, 64'h0);
      check("mrst_cols", 64'(faulty_cols), 64'h0);
      check("mrst_cnt", 64'(fault_col_cnt), 64'h0);
      check("mrst_rec", 64'(recoverable), 64'h1);
      check("mrst_busy", 64'(busy), 64'h0);
      check("mrst_done", 64'(done), 64'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         row_valid = 1'b1;
         golden_in = 19'($urandom);
         tick();
         check("mrst_no_done", 64'(done), 64'h0);
         check("mrst_idle_busy", 64'(busy), 64'h0);
      end
      row_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
